// File: rtl/apb4_mst_bridge.sv
// apb4_mst_bridge: single-outstanding valid/ready to APB4 initiator with access timeout
module apb4_mst_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_wstrb_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_prot_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [2:0]            apb_pprot_o,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [DATA_WIDTH-1:0] apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic                  apb_pready_i,
  input  logic [DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                  apb_pslverr_i
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [2:0] prot_q, prot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, to_q, to_d;
  logic expired;
  assign expired = TIMEOUT_CYC != 0 && cnt_q == CW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    prot_d = prot_q;
    rdata_d = rdata_q;
    err_d = err_q;
    to_d = to_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d = req_addr_i;
        wstrb_d = req_wstrb_i;
        wdata_d = |req_wstrb_i ? req_wdata_i : '0;
        prot_d = req_prot_i;
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d = '0;
        state_d = ACCESS;
      end
      ACCESS: if (apb_pready_i) begin
        rdata_d = (|wstrb_q || apb_pslverr_i) ? '0 : apb_prdata_i;
        err_d = apb_pslverr_i;
        to_d = 1'b0;
        cnt_d = '0;
        state_d = RESP;
      end else if (expired) begin
        rdata_d = '0;
        err_d = 1'b1;
        to_d = 1'b1;
        cnt_d = '0;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      prot_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      prot_q <= prot_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o = err_q;
  assign rsp_timeout_o = to_q;
  assign apb_paddr_o = addr_q;
  assign apb_pprot_o = prot_q;
  assign apb_psel_o = state_q == SETUP || state_q == ACCESS;
  assign apb_penable_o = state_q == ACCESS;
  assign apb_pwrite_o = |wstrb_q;
  assign apb_pwdata_o = wdata_q;
  assign apb_pstrb_o = wstrb_q;
endmodule

// File: tb/tb_apb4_mst_bridge.sv
// tb_apb4_mst_bridge: directed self-checking bench for apb4_mst_bridge
module tb_apb4_mst_bridge;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, rsp_to;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, paddr, pwdata, prdata = 0;
  logic [3:0] req_wstrb = 0, pstrb;
  logic [2:0] req_prot = 0, pprot;
  logic psel, penable, pwrite, pready = 0, pslverr = 0;
  int n_chk = 0, n_fail = 0;
  apb4_mst_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata), .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
    .apb_paddr_o(paddr), .apb_pprot_o(pprot), .apb_psel_o(psel), .apb_penable_o(penable),
    .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb),
    .apb_pready_i(pready), .apb_prdata_i(prdata), .apb_pslverr_i(pslverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [2:0] p);
    req_addr = a;
    req_wstrb = s;
    req_wdata = d;
    req_prot = p;
    req_valid = 1;
    chk("acc_rdy", req_ready, 1);
    tick;
    req_valid = 0;
  endtask
  task automatic ack;
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk("ack_idle", {rsp_valid, req_ready}, 2'b01);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_rdy", req_ready, 1);
    chk("rst_out", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_to}, 0);
    chk("rst_addr", paddr, 0);
    rst = 0;
    pready = 1;
    prdata = 32'hA5A5_1234;
    do_req(32'h1000_0004, 4'b0000, 32'hDEAD_0000, 3'b101);
    chk("rd_setup", {psel, penable, pwrite, req_ready}, 4'b1000);
    chk("rd_pstrb", pstrb, 0);
    chk("rd_paddr", paddr, 32'h1000_0004);
    chk("rd_pprot", pprot, 3'b101);
    chk("rd_pwdata", pwdata, 0);
    tick;
    chk("rd_access", {psel, penable, rsp_valid}, 3'b110);
    tick;
    chk("rd_resp", {psel, penable, rsp_valid, rsp_err, rsp_to}, 5'b00100);
    chk("rd_rdata", rsp_rdata, 32'hA5A5_1234);
    ack;
    pready = 0;
    do_req(32'h2000_0010, 4'b0011, 32'hCAFE_BEEF, 3'b000);
    chk("wr_setup", {psel, penable, pwrite}, 3'b101);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pready = 1;
      chk("wr_acc", {psel, penable, rsp_valid}, 3'b110);
      chk("wr_pwdata", pwdata, 32'hCAFE_BEEF);
      chk("wr_pstrb", pstrb, 4'b0011);
      chk("wr_paddr", paddr, 32'h2000_0010);
      tick;
    end
    chk("wr_resp", {psel, rsp_valid, rsp_err, rsp_to}, 4'b0100);
    chk("wr_rdata", rsp_rdata, 0);
    ack;
    pready = 1;
    pslverr = 1;
    prdata = 32'hFFFF_FFFF;
    do_req(32'h0000_0030, 4'b0000, 0, 3'b000);
    tick;
    tick;
    chk("err_resp", {rsp_valid, rsp_err, rsp_to}, 3'b110);
    chk("err_rdata", rsp_rdata, 0);
    ack;
    pready = 0;
    pslverr = 0;
    do_req(32'h0000_0034, 4'b0000, 0, 3'b000);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("to_acc", {psel, penable, rsp_valid}, 3'b110);
      tick;
    end
    chk("to_resp", {psel, penable, rsp_valid, rsp_err, rsp_to}, 5'b00111);
    chk("to_rdata", rsp_rdata, 0);
    ack;
    pready = 1;
    prdata = 32'h1234_5678;
    do_req(32'h0000_0038, 4'b0000, 0, 3'b000);
    tick;
    tick;
    chk("post_to_resp", {rsp_valid, rsp_err, rsp_to}, 3'b100);
    chk("post_to_rdata", rsp_rdata, 32'h1234_5678);
    ack;
    pready = 0;
    prdata = 32'h0BAD_F00D;
    do_req(32'h0000_003C, 4'b0000, 0, 3'b000);
    tick;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) pready = 1;
      chk("last_acc", {psel, penable, rsp_valid}, 3'b110);
      tick;
    end
    chk("last_resp", {rsp_valid, rsp_err, rsp_to}, 3'b100);
    chk("last_rdata", rsp_rdata, 32'h0BAD_F00D);
    ack;
    pready = 1;
    prdata = 32'h55AA_00FF;
    do_req(32'h0000_0020, 4'b0000, 0, 3'b000);
    tick;
    tick;
    req_addr = 32'h0000_0040;
    req_wstrb = 0;
    req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, req_ready, psel}, 3'b100);
      chk("bp_rdata", rsp_rdata, 32'h55AA_00FF);
      tick;
    end
    rsp_ready = 1;
    chk("bp_rdy_lo", req_ready, 0);
    tick;
    rsp_ready = 0;
    chk("bp_idle", {rsp_valid, req_ready, psel}, 3'b010);
    tick;
    req_valid = 0;
    chk("bp_setup", {psel, penable}, 2'b10);
    chk("bp_paddr", paddr, 32'h0000_0040);
    tick;
    tick;
    chk("bp_resp2", rsp_valid, 1);
    ack;
    pready = 0;
    do_req(32'h0000_0050, 4'b1111, 32'h0102_0304, 3'b000);
    tick;
    chk("mid_acc", {psel, penable}, 2'b11);
    rst = 1;
    tick;
    chk("mid_rst", {psel, penable, req_ready, rsp_valid}, 4'b0010);
    chk("mid_addr", paddr, 0);
    rst = 0;
    tick;
    chk("mid_after", {psel, rsp_valid, req_ready}, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
